// File: rtl/alu_pipe.sv
// Pipelined RV32I-style ALU with valid/ready handshakes on both sides and full backpressure.
// Stage 1 holds operands, the ALU sits between stages 1 and 2, and stages 3..STAGES only add delay.
module alu_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [2:0]        operation,
    input  logic              logic_arithmetic,
    input  logic              add_sub,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);
    localparam int SH = $clog2(DATA_W);

    logic [STAGES:1]          r_valid;
    logic [STAGES:1]          w_valid_next;
    logic [STAGES:1]          w_adv;
    logic [STAGES:1]          w_load;
    logic                     r_busy;

    logic [DATA_W-1:0]        r_a;
    logic [DATA_W-1:0]        r_b;
    logic [2:0]               r_op;
    logic                     r_sra;
    logic                     r_sub;
    logic [TAG_W-1:0]         r_tag  [1:STAGES];
    logic [DATA_W-1:0]        r_res  [2:STAGES];
    logic                     r_zero [2:STAGES];

    logic [DATA_W-1:0]        w_alu;
    logic signed [DATA_W-1:0] w_sra;
    logic [SH-1:0]            w_shamt;

    // Ready ripples from the output back to stage 1 so bubbles are squeezed out.
    always_comb begin
        w_adv        = '0;
        w_load       = '0;
        w_valid_next = r_valid;
        w_adv[STAGES]  = r_valid[STAGES] & out_ready & ~flush;
        w_load[STAGES] = ~r_valid[STAGES] | w_adv[STAGES];
        for (int k = STAGES - 1; k >= 1; k--) begin
            w_adv[k]  = r_valid[k] & w_load[k+1];
            w_load[k] = ~r_valid[k] | w_adv[k];
        end
        if (flush) begin
            w_valid_next = '0;
        end else begin
            w_valid_next[1] = w_load[1] ? in_valid : r_valid[1];
            for (int k = 2; k <= STAGES; k++) begin
                w_valid_next[k] = w_load[k] ? r_valid[k-1] : r_valid[k];
            end
        end
    end

    assign in_ready = w_load[1] & ~flush;

    assign w_shamt = r_b[SH-1:0];
    assign w_sra   = $signed(r_a) >>> w_shamt;

    always_comb begin
        w_alu = '0;
        case (r_op)
            3'b000:  w_alu = r_sub ? (r_a - r_b) : (r_a + r_b);
            3'b001:  w_alu = r_a << w_shamt;
            3'b010:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            3'b011:  w_alu = {{(DATA_W-1){1'b0}}, (r_a < r_b)};
            3'b100:  w_alu = r_a ^ r_b;
            3'b101:  w_alu = r_sra ? w_sra : (r_a >> w_shamt);
            3'b110:  w_alu = r_a | r_b;
            default: w_alu = r_a & r_b;
        endcase
    end

    // Data registers only load from a valid source and simply hold across a flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
            r_busy  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_sra   <= 1'b0;
            r_sub   <= 1'b0;
            for (int k = 1; k <= STAGES; k++) begin
                r_tag[k] <= '0;
            end
            for (int k = 2; k <= STAGES; k++) begin
                r_res[k]  <= '0;
                r_zero[k] <= 1'b0;
            end
        end else begin
            r_valid <= w_valid_next;
            r_busy  <= |w_valid_next;
            if (!flush && in_valid && w_load[1]) begin
                r_a      <= operand_a;
                r_b      <= operand_b;
                r_op     <= operation;
                r_sra    <= logic_arithmetic;
                r_sub    <= add_sub;
                r_tag[1] <= in_tag;
            end
            if (!flush && r_valid[1] && w_load[2]) begin
                r_res[2]  <= w_alu;
                r_zero[2] <= (w_alu == '0);
                r_tag[2]  <= r_tag[1];
            end
            for (int k = 3; k <= STAGES; k++) begin
                if (!flush && r_valid[k-1] && w_load[k]) begin
                    r_res[k]  <= r_res[k-1];
                    r_zero[k] <= r_zero[k-1];
                    r_tag[k]  <= r_tag[k-1];
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES];
    assign alu_out   = r_res[STAGES];
    assign zero      = r_zero[STAGES];
    assign out_tag   = r_tag[STAGES];
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a 32-bit/4-stage instance and an 8-bit/2-stage instance.
`timescale 1ns/1ps
module tb_alu_pipe;
    localparam int S  = 4;
    localparam int S8 = 2;

    typedef struct {
        logic [31:0] data;
        logic        z;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, flush, in_valid, in_ready, out_valid, out_ready, zero, busy, la, asb;
    logic [31:0] a, b, alu_out;
    logic [2:0]  op;
    logic [3:0]  in_tag, out_tag;

    logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8, zero8, busy8, la8, as8;
    logic [7:0]  a8, b8, alu8;
    logic [2:0]  op8;
    logic [3:0]  tag8, otag8;

    alu_pipe #(.DATA_W(32), .STAGES(S), .TAG_W(4)) u_dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(a), .operand_b(b), .operation(op), .logic_arithmetic(la), .add_sub(asb),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
        .zero(zero), .out_tag(out_tag), .busy(busy)
    );

    alu_pipe #(.DATA_W(8), .STAGES(S8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rstn(rstn), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
        .operand_a(a8), .operand_b(b8), .operation(op8), .logic_arithmetic(la8), .add_sub(as8),
        .in_tag(tag8), .out_valid(out_valid8), .out_ready(out_ready8), .alu_out(alu8),
        .zero(zero8), .out_tag(otag8), .busy(busy8)
    );

    int          checks = 0;
    int          passed = 0;
    exp_t        sb[$];
    exp_t        sb8[$];
    exp_t        cur, cur8;
    int          cyc = 0;
    int          seen = -1;
    int          seen8 = -1;
    bit          lat_chk = 0;
    bit          hold_v = 0;
    logic [31:0] hold_d;
    logic [3:0]  hold_t;
    logic        hold_z;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: captures accepted inputs into the scoreboards and checks every output transfer.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rstn) begin
            seen   = -1;
            seen8  = -1;
            hold_v = 0;
        end else begin
            if (!out_valid) seen = -1;
            else if (seen < 0) seen = cyc;
            if (!out_valid8) seen8 = -1;
            else if (seen8 < 0) seen8 = cyc;

            if (hold_v && out_valid) begin
                chk("hold_data", alu_out, hold_d);
                chk("hold_tag", out_tag, hold_t);
                chk("hold_zero", zero, hold_z);
            end

            if (in_valid && in_ready) begin
                e = cur; e.acc = cyc; sb.push_back(e);
            end
            if (in_valid8 && in_ready8) begin
                e = cur8; e.acc = cyc; sb8.push_back(e);
            end

            if (out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: got tag 0x%0h data 0x%08h, required no output", out_tag, alu_out);
                end else begin
                    e = sb.pop_front();
                    $display("out32 tag=0x%0h data=0x%08h zero=%0b (expect 0x%08h)", out_tag, alu_out, zero, e.data);
                    chk($sformatf("data_tag%0h", e.tag), alu_out, e.data);
                    chk($sformatf("zero_tag%0h", e.tag), zero, e.z);
                    chk("tag_order", out_tag, e.tag);
                    if (lat_chk) chk($sformatf("latency_tag%0h", e.tag), seen - e.acc, S);
                end
                seen = -1;
            end

            if (out_valid8 && out_ready8) begin
                if (sb8.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out8: got tag 0x%0h data 0x%02h, required no output", otag8, alu8);
                end else begin
                    e = sb8.pop_front();
                    $display("out8 tag=0x%0h data=0x%02h zero=%0b (expect 0x%02h)", otag8, alu8, zero8, e.data[7:0]);
                    chk($sformatf("data8_tag%0h", e.tag), alu8, e.data[7:0]);
                    chk($sformatf("zero8_tag%0h", e.tag), zero8, e.z);
                    chk("tag8_order", otag8, e.tag);
                    chk($sformatf("latency8_tag%0h", e.tag), seen8 - e.acc, S8);
                end
                seen8 = -1;
            end

            hold_v = out_valid && !out_ready;
            hold_d = alu_out;
            hold_t = out_tag;
            hold_z = zero;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xs, input logic xl, input logic [3:0] t, input logic [31:0] ex);
        bit acc;
        op = o; a = xa; b = xb; asb = xs; la = xl; in_tag = t; in_valid = 1'b1;
        cur.data = ex; cur.z = (ex == 32'h0); cur.tag = t; cur.acc = 0;
        acc = 0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++;
            $display("FAIL accept_timeout: tag 0x%0h not accepted, required acceptance within 200 cycles", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                         input logic xs, input logic xl, input logic [3:0] t, input logic [7:0] ex);
        bit acc;
        op8 = o; a8 = xa; b8 = xb; as8 = xs; la8 = xl; tag8 = t; in_valid8 = 1'b1;
        cur8.data = {24'h0, ex}; cur8.z = (ex == 8'h0); cur8.tag = t; cur8.acc = 0;
        acc = 0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk); acc = in_ready8;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++;
            $display("FAIL accept8_timeout: tag 0x%0h not accepted, required acceptance within 200 cycles", t);
        end
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (sb.size() == 0 && sb8.size() == 0 && !busy && !busy8) break;
            @(posedge clk); #1;
        end
        chk("drain_pending", sb.size() + sb8.size(), 0);
        chk("drain_busy", {busy, busy8}, 2'b00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx, t0;
        bit  acc, done;
        rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0; la = 1'b0; asb = 1'b0; in_tag = '0;
        flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        a8 = '0; b8 = '0; op8 = '0; la8 = 1'b0; as8 = 1'b0; tag8 = '0;
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_zero", zero, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid8", out_valid8, 0);
        @(posedge clk); #1 rstn = 1'b1;
        idle(1);

        // Arithmetic / logic corners, out_ready held high, exact latency checked
        lat_chk = 1;
        send(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 4'h1, 32'h0000_0000);
        send(3'b000, 32'h0000_0000, 32'h0000_0001, 1, 0, 4'h2, 32'hFFFF_FFFF);
        send(3'b010, 32'h8000_0000, 32'h0000_0001, 0, 0, 4'h3, 32'h0000_0001);
        send(3'b011, 32'h8000_0000, 32'h0000_0001, 0, 0, 4'h4, 32'h0000_0000);
        send(3'b101, 32'h8000_0000, 32'h0000_0021, 0, 1, 4'h5, 32'hC000_0000);
        send(3'b101, 32'h8000_0000, 32'h0000_0021, 0, 0, 4'h6, 32'h4000_0000);
        send(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 0, 4'h7, 32'h0FF0_0FF0);
        send(3'b110, 32'h1234_0000, 32'h0000_5678, 0, 1, 4'h8, 32'h1234_5678);
        send(3'b111, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 4'h9, 32'h0F0F_0000);
        send(3'b001, 32'h0000_0001, 32'h0000_003F, 0, 0, 4'hA, 32'h8000_0000);
        send(3'b010, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 4'hB, 32'h0000_0001);
        send(3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 4'hC, 32'h0000_0000);
        send(3'b000, 32'h0000_0005, 32'h0000_0007, 0, 1, 4'hD, 32'h0000_000C);
        drain();

        // Back-to-back: 16 ops, one accepted per cycle
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            send(3'b000, 32'h0101_0101 * i, 32'(i), 0, 0, 4'(i), 32'h0101_0101 * i + 32'(i));
        end
        chk("b2b_cycles", cyc - t0, 16);
        drain();

        // Backpressure: pipe must fill to exactly S entries and then refuse input
        lat_chk = 0;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            op = 3'b111; a = 32'hFFFF_FFFF; b = 32'h1111_1111 * (idx + 1); asb = 0; la = 0;
            in_tag = 4'(idx); in_valid = 1'b1;
            cur.data = b; cur.z = 1'b0; cur.tag = in_tag; cur.acc = 0;
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_accepted", idx, S);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 1);
        in_valid = 1'b0;
        done = 0;
        fork
            begin
                for (int k = idx; k < 10; k++) begin
                    send(3'b111, 32'hFFFF_FFFF, 32'h1111_1111 * (k + 1), 0, 0, 4'(k), 32'h1111_1111 * (k + 1));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Flush with three ops in flight and a simultaneous input offer
        out_ready = 1'b0;
        send(3'b110, 32'h0000_0001, 32'h0000_0010, 0, 0, 4'h1, 32'h0000_0011);
        send(3'b110, 32'h0000_0002, 32'h0000_0020, 0, 0, 4'h2, 32'h0000_0022);
        send(3'b110, 32'h0000_0003, 32'h0000_0030, 0, 0, 4'h3, 32'h0000_0033);
        op = 3'b000; a = 32'h7; b = 32'h8; in_tag = 4'hF; in_valid = 1'b1;
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        idle(5);
        lat_chk = 1;
        send(3'b000, 32'h0000_0010, 32'h0000_0020, 0, 0, 4'hA, 32'h0000_0030);
        drain();

        // Asynchronous reset with work in flight
        lat_chk = 0;
        out_ready = 1'b0;
        send(3'b100, 32'h1234_5678, 32'h0000_0000, 0, 0, 4'h5, 32'h1234_5678);
        send(3'b100, 32'h0000_00FF, 32'h0000_000F, 0, 0, 4'h6, 32'h0000_00F0);
        idle(3);
        chk("prerst_out_valid", out_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_alu_out", alu_out, 0);
        chk("midrst_out_tag", out_tag, 0);
        chk("midrst_busy", busy, 0);
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        idle(10);
        chk("postrst_out_valid", out_valid, 0);
        chk("postrst_busy", busy, 0);

        // 8-bit, 2-stage instance
        send8(3'b001, 8'h01, 8'h0F, 0, 0, 4'h1, 8'h80);
        send8(3'b111, 8'hF0, 8'h3C, 0, 0, 4'h2, 8'h30);
        send8(3'b100, 8'h55, 8'h55, 0, 0, 4'h3, 8'h00);
        send8(3'b101, 8'h80, 8'h09, 0, 1, 4'h4, 8'hC0);
        send8(3'b000, 8'hFF, 8'h01, 0, 0, 4'h5, 8'h00);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-shot registered ALU wrapper.
- Accepts RV32I-style ALU operations through a valid/ready input handshake and carries each operation through STAGES register stages with full backpressure.
- Returns the result with a zero flag and a caller-supplied tag on a valid/ready output handshake.
- Sits between the decode/issue logic and writeback in each core of the multicore design.

Parameters:
- DATA_W, 32: operand/result width; power of two, 8..64.
- STAGES, 2: pipeline register stages from input to output; 2..8.
  - Stage 1 captures the operands.
  - The ALU is combinational between stage 1 and stage 2.
  - Stages 3..STAGES are delay.
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- operand_a  in  DATA_W  source operand A.
- operand_b  in  DATA_W  source operand B.
- operation  in  3  funct3-style opcode.
- logic_arithmetic  in  1  selects SRA over SRL when operation=101.
- add_sub  in  1  selects SUB over ADD when operation=000.
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- alu_out  out  DATA_W  result.
- zero  out  1  alu_out == 0.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  any stage holds a valid operation.

Behaviour:
- Reset (rstn low, async): all stage valid bits 0, all stage data/tag registers 0. Therefore out_valid=0, alu_out=0, zero=0, out_tag=0, busy=0. Reset asserted mid-operation discards in-flight work with no output.
- Opcode encoding, SH = log2(DATA_W) bits of operand_b:
  - 000 ADD, or SUB if add_sub=1; wrap-around modulo 2^DATA_W, no carry out.
  - 001 SLL by operand_b[SH-1:0].
  - 010 SLT signed, result 0 or 1 zero-extended.
  - 011 SLTU unsigned, 0 or 1.
  - 100 XOR.
  - 101 SRL, or SRA if logic_arithmetic=1; shift amount as SLL.
  - 110 OR.
  - 111 AND.
- add_sub is ignored except for opcode 000; logic_arithmetic is ignored except for opcode 101.
- Handshake:
  - A transfer occurs on a rising edge where valid & ready are both high.
  - Producer/consumer must hold data stable while valid is high and ready is low; the block holds alu_out/zero/out_tag stable while out_valid=1 and out_ready=0.
- Pipeline advance:
  - Stage k loads from stage k-1 when stage k is empty or stage k is advancing.
  - The last stage advances when out_valid & out_ready.
  - in_ready = !v1 | advance1. This is combinational from out_ready through the chain; bubbles are compressed.
- Latency: with out_ready held high, an operation accepted at edge N presents out_valid=1 after edge N+STAGES-1 and is consumed at edge N+STAGES-1+1. Throughput is 1 op/cycle.
- Ordering: strict in-order; tag returned unchanged with its own result.
- Stall: with out_ready=0, the pipe fills to STAGES operations and then in_ready=0. No operation is dropped or duplicated.
- zero: registered with alu_out in stage 2 (not recomputed at output); equals (result==0) of that operation.
- flush:
  - At the next edge, all valid bits clear; data registers hold.
  - in_ready=0 during the flush cycle, so an input offered while flush=1 is not accepted.
  - flush dominates simultaneous in/out handshakes; an output with out_ready=1 during flush is not counted as a transfer.
- busy = OR of all stage valid bits, registered.
- Results are a pure function of the captured operands; no state persists between operations.

Test Plan:
- Reset, STAGES=2: rstn low mid-stream with 2 ops in flight -> out_valid=0, alu_out=0, busy=0 immediately; no results after rstn release.
- Arithmetic corners, DATA_W=32, STAGES=2, out_ready=1:
  - ADD 0xFFFFFFFF+1 -> alu_out=0, zero=1, latency 2.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SLT 0x80000000,1 -> 1.
  - SLTU same operands -> 0.
  - SRA 0x80000000 by 0x21 (masked to 1) -> 0xC0000000.
  - SRL same -> 0x40000000.
- Back-to-back, STAGES=4, 16 ops with tags 0..15 -> results in order, one per cycle after a 4-cycle fill, tags match.
- Backpressure: out_ready=0 for 10 cycles while in_valid=1 -> exactly 4 accepted (STAGES=4), then in_ready=0. On release, 4 results drain in order with no loss/duplication; randomised out_ready with a scoreboard.
- Flush: 3 ops in flight plus in_valid=1 and flush=1 at the same edge -> next cycle out_valid=0, busy=0, the offered op is not accepted; a following op tagged 0xA returns correctly.
- Width variant DATA_W=8: SLL 0x01 by 0x0F (masked 7) -> 0x80; AND 0xF0&0x3C -> 0x30; XOR 0x55^0x55 -> 0x00 with zero=1.
